// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 8;
    localparam int IDX_W  = 4;
    localparam int WCNT_W = 3;

    localparam logic [APB_AW-1:0] ID_ADDR_DEF  = 8'hFF;
    localparam logic [APB_DW-1:0] ID_VALUE_DEF = 8'hA5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slv_decode.sv
// Combinational address decode: R/W register window, ID register, or unmapped.
module apb_slv_decode
    import apb_pkg::*;
#(
    parameter int                NUM_REGS = 4,
    parameter logic [APB_AW-1:0] ID_ADDR  = ID_ADDR_DEF
) (
    input  logic [APB_AW-1:0] addr,
    input  logic              write,
    output logic [IDX_W-1:0]  idx,
    output logic              hit_rw,
    output logic              hit_id,
    output logic              err
);

    localparam logic [APB_AW-1:0] RW_LIMIT = APB_AW'(NUM_REGS);

    always_comb begin
        idx    = addr[IDX_W-1:0];
        hit_rw = (addr < RW_LIMIT);
        hit_id = (addr == ID_ADDR);
        // The ID register is read-only, so writing it counts as an error.
        err    = (!hit_rw && !hit_id) || (hit_id && write);
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS R/W registers, a read-only ID register and
// programmable wait states. Slave errors are reported only with APB_SLV_ERR_EN.
//
//   state  | meaning
//   IDLE   | no transfer in flight, waiting for a setup phase
//   ACCESS | access phase: counting wait states, then completing
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                NUM_REGS    = 4,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [APB_AW-1:0] ID_ADDR     = ID_ADDR_DEF,
    parameter logic [APB_DW-1:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [APB_AW-1:0]          paddr,
    input  logic [APB_DW-1:0]          pwdata,
    output logic [APB_DW-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [APB_DW*NUM_REGS-1:0] regs_flat
);

    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES);
    localparam logic              ZERO_WAIT = (WAIT_CYCLES == 0);

    apb_state_e          state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [APB_AW-1:0]   addr_q, addr_d;
    logic [APB_DW-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [APB_DW-1:0]   prdata_q, prdata_d;
    logic [APB_DW-1:0]   regs_q [NUM_REGS];
    logic [APB_DW-1:0]   regs_d [NUM_REGS];

    logic                setup;
    logic [APB_AW-1:0]   dec_addr;
    logic                dec_write;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_hit_rw;
    logic                dec_hit_id;
    logic                dec_err;
    logic                err_eff;
    logic [APB_DW-1:0]   rw_val;
    logic [APB_DW-1:0]   resp_data;
    logic                commit;

    assign setup = psel && !penable;

    // A zero-wait setup must respond on the same edge it latches, so the
    // decoder looks at the live bus during setup and the latched copy otherwise.
    assign dec_addr  = setup ? paddr  : addr_q;
    assign dec_write = setup ? pwrite : write_q;

    apb_slv_decode #(
        .NUM_REGS (NUM_REGS),
        .ID_ADDR  (ID_ADDR)
    ) u_decode (
        .addr   (dec_addr),
        .write  (dec_write),
        .idx    (dec_idx),
        .hit_rw (dec_hit_rw),
        .hit_id (dec_hit_id),
        .err    (dec_err)
    );

`ifdef APB_SLV_ERR_EN
    assign err_eff = dec_err;
`else
    assign err_eff = 1'b0;
`endif

    always_comb begin
        rw_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_idx == IDX_W'(i)) rw_val = regs_q[i];
        end
    end

    always_comb begin
        resp_data = '0;
        if (!dec_write && !dec_err) begin
            if (dec_hit_rw)      resp_data = rw_val;
            else if (dec_hit_id) resp_data = ID_VALUE;
        end
    end

    assign commit = (state_q == ACCESS) && psel && penable && pready_q &&
                    write_q && dec_hit_rw;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && (dec_idx == IDX_W'(i))) regs_d[i] = wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;

        if (setup) begin
            // Also covers penable dropping mid-access: restart as a fresh setup.
            state_d   = ACCESS;
            addr_d    = paddr;
            wdata_d   = pwdata;
            write_d   = pwrite;
            wcnt_d    = WAIT_INIT;
            pready_d  = ZERO_WAIT;
            pslverr_d = ZERO_WAIT && err_eff;
            prdata_d  = ZERO_WAIT ? resp_data : '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ACCESS: begin
                    if (!psel) begin
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else if (pready_q) begin
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else begin
                        if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
                        if (wcnt_q <= WCNT_W'(1)) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_eff;
                            prdata_d  = resp_data;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[APB_DW*g +: APB_DW] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: instance 0 has no wait states, instance 1 has one.
module tb_apb_slave_regfile;

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        pclk;
    logic        presetn;
    logic        psel_a    [2];
    logic        penable_a [2];
    logic        pwrite_a  [2];
    logic [7:0]  paddr_a   [2];
    logic [7:0]  pwdata_a  [2];
    logic [7:0]  prdata_a  [2];
    logic        pready_a  [2];
    logic        pslverr_a [2];
    logic [31:0] rf_a      [2];

    logic [7:0]  mdl [2][4];
    int          total;
    int          bad;

    apb_slave_regfile #(.NUM_REGS(4), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_a[0]), .penable(penable_a[0]),
        .pwrite(pwrite_a[0]), .paddr(paddr_a[0]), .pwdata(pwdata_a[0]),
        .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]),
        .regs_flat(rf_a[0])
    );

    apb_slave_regfile #(.NUM_REGS(4), .WAIT_CYCLES(1)) dut1 (
        .pclk(pclk), .presetn(presetn), .psel(psel_a[1]), .penable(penable_a[1]),
        .pwrite(pwrite_a[1]), .paddr(paddr_a[1]), .pwdata(pwdata_a[1]),
        .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]),
        .regs_flat(rf_a[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) mdl[k][i] = 8'h00;
    endtask

    // Expected response of a transfer, straight from the address map rules.
    task automatic model_resp(input int k, input bit wr, input logic [7:0] a,
                              output logic [7:0] ed, output logic ee, output bit cm);
        bit hit_rw, hit_id, err;
        hit_rw = (a < 8'd4);
        hit_id = (a == 8'hFF);
        err    = (!hit_rw && !hit_id) || (hit_id && wr);
        ee     = ERR_EN && err;
        cm     = wr && hit_rw;
        if (wr || err)   ed = 8'h00;
        else if (hit_rw) ed = mdl[k][a[1:0]];
        else             ed = 8'hA5;
    endtask

    task automatic idle_cycle();
        @(posedge pclk); #1;
    endtask

    // Starts #1 after an edge; returns #1 after the completion (or abort) edge.
    task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit abort, output logic [7:0] rd, output logic er,
                        output int cycles);
        logic [7:0] ed;
        logic       ee;
        bit         cm;
        bit         done;
        int         cyc;
        model_resp(k, wr, a, ed, ee, cm);
        rd = 8'h00;
        er = 1'b0;
        psel_a[k] = 1'b1; penable_a[k] = 1'b0; pwrite_a[k] = wr;
        paddr_a[k] = a; pwdata_a[k] = d;
        @(posedge pclk); #1;
        penable_a[k] = 1'b1;
        cyc  = 1;
        done = 1'b0;
        if (abort) begin
            psel_a[k] = 1'b0; penable_a[k] = 1'b0;
            @(posedge pclk); #1;
            chk("abort_pready", {31'd0, pready_a[k]}, 32'd0);
            cycles = 2;
            return;
        end
        while (!done && cyc <= 20) begin
            if (pready_a[k]) begin
                rd = prdata_a[k];
                er = pslverr_a[k];
                chk("latency", cyc, wait_of(k) + 1);
                chk("prdata", {24'd0, rd}, {24'd0, ed});
                chk("pslverr", {31'd0, er}, {31'd0, ee});
                done = 1'b1;
            end else begin
                @(posedge pclk); #1;
                cyc++;
            end
        end
        if (!done) chk("pready_timeout", cyc, wait_of(k) + 1);
        @(posedge pclk); #1;
        if (cm && done) mdl[k][a[1:0]] = d;
        psel_a[k] = 1'b0; penable_a[k] = 1'b0;
        cycles = cyc + 1;
    endtask

    // Per-cycle compare against the model on the falling edge.
    always @(negedge pclk) begin
        for (int k = 0; k < 2; k++) begin
            chk("regs_flat", rf_a[k], {mdl[k][3], mdl[k][2], mdl[k][1], mdl[k][0]});
            if (!pready_a[k]) begin
                chk("prdata_idle", {24'd0, prdata_a[k]}, 32'd0);
                chk("pslverr_idle", {31'd0, pslverr_a[k]}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] rd;
        logic       er;
        int         cyc;
        total = 0;
        bad   = 0;
        clear_model();
        presetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            psel_a[k] = 1'b0; penable_a[k] = 1'b0; pwrite_a[k] = 1'b0;
            paddr_a[k] = 8'h00; pwdata_a[k] = 8'h00;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pready", {31'd0, pready_a[k]}, 32'd0);
            chk("rst_prdata", {24'd0, prdata_a[k]}, 32'd0);
            chk("rst_regs", rf_a[k], 32'd0);
        end
        presetn = 1'b1;
        idle_cycle();

        // One wait state: write then read back register 2.
        xfer(1, 1'b1, 8'h02, 8'h3C, 1'b0, rd, er, cyc);
        chk("wr02_cycles", cyc, 3);
        chk("wr02_err", {31'd0, er}, 32'd0);
        chk("wr02_reg", {24'd0, rf_a[1][23:16]}, 32'h3C);
        idle_cycle();
        xfer(1, 1'b0, 8'h02, 8'h00, 1'b0, rd, er, cyc);
        chk("rd02_data", {24'd0, rd}, 32'h3C);
        chk("rd02_cycles", cyc, 3);
        xfer(1, 1'b0, 8'hFF, 8'h00, 1'b0, rd, er, cyc);
        chk("rdid_data", {24'd0, rd}, 32'hA5);
        chk("rdid_err", {31'd0, er}, 32'd0);
        xfer(1, 1'b1, 8'hFF, 8'h11, 1'b0, rd, er, cyc);
        chk("wrid_err", {31'd0, er}, {31'd0, ERR_EN});
        xfer(1, 1'b0, 8'hFF, 8'h00, 1'b0, rd, er, cyc);
        chk("rdid_again", {24'd0, rd}, 32'hA5);
        xfer(1, 1'b0, 8'h40, 8'h00, 1'b0, rd, er, cyc);
        chk("rd40_data", {24'd0, rd}, 32'd0);
        chk("rd40_err", {31'd0, er}, {31'd0, ERR_EN});

        // Zero wait states: back-to-back writes, two cycles each.
        xfer(0, 1'b1, 8'h00, 8'h5A, 1'b0, rd, er, cyc);
        chk("b2b0_cycles", cyc, 2);
        xfer(0, 1'b1, 8'h01, 8'h6B, 1'b0, rd, er, cyc);
        chk("b2b1_cycles", cyc, 2);
        chk("b2b_regs", {16'd0, rf_a[0][15:0]}, 32'h6B5A);

        // Reset during the wait state of a write to register 1.
        psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
        paddr_a[1] = 8'h01; pwdata_a[1] = 8'h77;
        @(posedge pclk); #1;
        penable_a[1] = 1'b1;
        presetn = 1'b0;
        clear_model();
        #2;
        chk("mid_rst_pready", {31'd0, pready_a[1]}, 32'd0);
        chk("mid_rst_prdata", {24'd0, prdata_a[1]}, 32'd0);
        chk("mid_rst_pslverr", {31'd0, pslverr_a[1]}, 32'd0);
        chk("mid_rst_reg1", {24'd0, rf_a[1][15:8]}, 32'd0);
        psel_a[1] = 1'b0; penable_a[1] = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle_cycle();
        xfer(1, 1'b1, 8'h01, 8'h42, 1'b0, rd, er, cyc);
        chk("post_rst_reg1", {24'd0, rf_a[1][15:8]}, 32'h42);
        xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, rd, er, cyc);
        chk("post_rst_rd1", {24'd0, rd}, 32'h42);

        // Randomized traffic on both instances, including aborted transfers.
        for (int n = 0; n < 200; n++) begin
            int         k;
            int         pick;
            bit         wr;
            bit         ab;
            logic [7:0] a;
            logic [7:0] d;
            k    = int'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            wr   = 1'($urandom_range(0, 1));
            ab   = ($urandom_range(0, 9) == 0);
            d    = 8'($urandom);
            if (pick < 6)      a = 8'($urandom_range(0, 3));
            else if (pick < 8) a = 8'hFF;
            else               a = 8'($urandom);
            xfer(k, wr, a, d, ab, rd, er, cyc);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
